// File: rtl/prog_loader_spi.sv
// prog_loader_spi: loads a checksummed SPI program frame into instruction memory and releases the core when verified
module prog_loader_spi (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       core_run,
    output logic       load_err,
    output logic [2:0] state_dbg
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    logic [1:0] sck_s_q, sck_s_d, mosi_s_q, mosi_s_d, cs_s_q, cs_s_d, vld_q, vld_d;
    logic       sck_p_q, sck_p_d, cs_p_q, cs_p_d, armed_q, armed_d, wr_en_q, wr_en_d;
    logic [7:0] shift_q, shift_d, sum_q, sum_d, wr_data_q, wr_data_d;
    logic [2:0] bit_q, bit_d, state_q, state_d;
    logic [3:0] cnt_q, cnt_d, addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic       sck_rise, cs_rise, cs_fall, shifting, byte_done;
    logic [7:0] byte_val;

    // A cs_n fall only counts once cs_n has been seen high from the pin after reset,
    // so a reset in mid-frame cannot restart the load from the reset-forced sync level.
    assign sck_rise  = sck_s_q[1] & ~sck_p_q;
    assign cs_rise   = cs_s_q[1] & ~cs_p_q;
    assign cs_fall   = ~cs_s_q[1] & cs_p_q & armed_q;
    assign shifting  = sck_rise & ~cs_s_q[1];
    assign byte_val  = {shift_q[6:0], mosi_s_q[1]};
    assign byte_done = shifting & (bit_q == 3'd7);

    always_comb begin
        sck_s_d   = {sck_s_q[0], spi_sck};
        mosi_s_d  = {mosi_s_q[0], spi_mosi};
        cs_s_d    = {cs_s_q[0], spi_cs_n};
        sck_p_d   = sck_s_q[1];
        cs_p_d    = cs_s_q[1];
        vld_d     = {vld_q[0], 1'b1};
        armed_d   = armed_q | (vld_q[1] & cs_s_q[1]);
        shift_d   = shifting ? byte_val : shift_q;
        bit_d     = shifting ? bit_q + 3'd1 : bit_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        sum_d     = sum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_HEADER: if (byte_done) begin
                state_d = (byte_val[7:4] == 4'hA) ? S_DATA : S_ERROR;
                cnt_d   = byte_val[3:0];
            end
            S_DATA: if (byte_done) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = byte_val;
                sum_d     = sum_q + byte_val;
                addr_d    = addr_q + 4'd1;
                state_d   = (addr_q == cnt_q) ? S_CHECK : S_DATA;
            end
            S_CHECK: if (byte_done) state_d = (byte_val == sum_q) ? S_DONE : S_ERROR;
            S_DONE:  if (byte_done) state_d = S_ERROR;
            default: ;
        endcase
        // The completed byte is resolved first; a cs_n rise still aborts an unfinished frame.
        if (cs_rise && (state_d inside {S_HEADER, S_DATA, S_CHECK})) state_d = S_ERROR;
        if (cs_fall && (state_q inside {S_IDLE, S_DONE, S_ERROR})) begin
            state_d = S_HEADER;
            bit_d   = 3'd0;
            addr_d  = 4'd0;
            sum_d   = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s_q   <= 2'b00;
            mosi_s_q  <= 2'b00;
            cs_s_q    <= 2'b11;
            sck_p_q   <= 1'b0;
            cs_p_q    <= 1'b1;
            vld_q     <= 2'b00;
            armed_q   <= 1'b0;
            shift_q   <= 8'd0;
            bit_q     <= 3'd0;
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 4'd0;
            sum_q     <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= 8'd0;
        end else begin
            sck_s_q   <= sck_s_d;
            mosi_s_q  <= mosi_s_d;
            cs_s_q    <= cs_s_d;
            sck_p_q   <= sck_p_d;
            cs_p_q    <= cs_p_d;
            vld_q     <= vld_d;
            armed_q   <= armed_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            sum_q     <= sum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign core_run  = state_q == S_DONE;
    assign load_err  = state_q == S_ERROR;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_prog_loader_spi.sv
// tb_prog_loader_spi: scoreboard bench driving framed SPI loads into prog_loader_spi
module tb_prog_loader_spi;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       core_run, load_err;
    logic [2:0] state_dbg;
    int         vectors = 0;
    int         miscompares = 0;
    logic [11:0] exp_q[$];

    prog_loader_spi dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_run(core_run), .load_err(load_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write got addr=%h data=%h, expected no write", wr_addr, wr_data);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    miscompares++;
                    $display("FAIL write got addr=%h data=%h, expected addr=%h data=%h", wr_addr, wr_data, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk) spi_mosi = b[i];
            repeat (4) @(negedge clk);
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic cs_low();
        @(negedge clk) spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_status(input string name, input logic run, input logic err, input logic [2:0] st);
        vectors++;
        if ({core_run, load_err, state_dbg} !== {run, err, st}) begin
            miscompares++;
            $display("FAIL %s got run=%b err=%b state=%0d, expected run=%b err=%b state=%0d",
                     name, core_run, load_err, state_dbg, run, err, st);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_writes got %0d missing writes, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic good_frame();
        cs_low();
        send_byte(8'hA1);
        push(4'd0, 8'h81); send_byte(8'h81);
        push(4'd1, 8'h48); send_byte(8'h48);
        send_byte(8'hC9);
        cs_high();
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        vectors++;
        if ({wr_en, wr_addr, wr_data, core_run, load_err, state_dbg} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset got en=%b addr=%h data=%h run=%b err=%b state=%0d, expected all 0",
                     wr_en, wr_addr, wr_data, core_run, load_err, state_dbg);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_good_load();
        good_frame();
        check_status("good_load", 1'b1, 1'b0, 3'd4);
        vectors++;
        if ({wr_addr, wr_data} !== {4'd1, 8'h48}) begin
            miscompares++;
            $display("FAIL good_hold got addr=%h data=%h, expected addr=1 data=48", wr_addr, wr_data);
        end
    endtask

    task automatic test_full_image();
        cs_low();
        vectors++;
        if ({core_run, state_dbg} !== {1'b0, 3'd1}) begin
            miscompares++;
            $display("FAIL full_start got run=%b state=%0d, expected run=0 state=1", core_run, state_dbg);
        end
        send_byte(8'hAF);
        for (int i = 0; i < 16; i++) begin
            push(4'(i), 8'(i));
            send_byte(8'(i));
        end
        send_byte(8'h78);
        cs_high();
        check_status("full_image", 1'b1, 1'b0, 3'd4);
    endtask

    task automatic test_bad_checksum();
        cs_low();
        send_byte(8'hA0);
        push(4'd0, 8'hC0); send_byte(8'hC0);
        send_byte(8'hC1);
        repeat (3) @(negedge clk);
        check_status("bad_checksum", 1'b0, 1'b1, 3'd5);
        cs_high();
        check_status("bad_checksum_after", 1'b0, 1'b1, 3'd5);
    endtask

    task automatic test_back_to_back();
        cs_low();
        send_byte(8'h51);
        repeat (3) @(negedge clk);
        check_status("bad_magic", 1'b0, 1'b1, 3'd5);
        cs_high();
        cs_low();
        check_status("restart_clears", 1'b0, 1'b0, 3'd1);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check_status("restart_abort", 1'b0, 1'b1, 3'd5);
        good_frame();
        check_status("good_after_bad", 1'b1, 1'b0, 3'd4);
    endtask

    task automatic test_abort();
        cs_low();
        send_byte(8'hA3);
        push(4'd0, 8'h11); send_byte(8'h11);
        send_bits(8'h22, 4);
        cs_high();
        check_status("cs_abort", 1'b0, 1'b1, 3'd5);
        cs_low();
        send_byte(8'hA0);
        push(4'd0, 8'h05); send_byte(8'h05);
        send_byte(8'h05);
        repeat (3) @(negedge clk);
        check_status("extra_pre", 1'b1, 1'b0, 3'd4);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        check_status("extra_byte", 1'b0, 1'b1, 3'd5);
        cs_high();
    endtask

    task automatic test_rst_mid_frame();
        cs_low();
        send_byte(8'hA1);
        push(4'd0, 8'h81); send_byte(8'h81);
        send_bits(8'h48, 4);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        vectors++;
        if ({wr_en, wr_addr, wr_data, core_run, load_err, state_dbg} !== 17'd0) begin
            miscompares++;
            $display("FAIL rst_mid got en=%b addr=%h data=%h run=%b err=%b state=%0d, expected all 0",
                     wr_en, wr_addr, wr_data, core_run, load_err, state_dbg);
        end
        exp_q.delete();
        send_bits(8'h48, 4);
        send_byte(8'hC9);
        send_byte(8'h33);
        repeat (3) @(negedge clk);
        check_status("rst_ignore", 1'b0, 1'b0, 3'd0);
        cs_high();
        check_status("rst_idle", 1'b0, 1'b0, 3'd0);
        good_frame();
        check_status("rst_recover", 1'b1, 1'b0, 3'd4);
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_full_image();
        test_bad_checksum();
        test_back_to_back();
        test_abort();
        test_rst_mid_frame();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/prog_loader_spi.md
# prog_loader_spi

- Upstream program loader for the tiny RISC core.
- Receives a framed program image over a 3-wire SPI-style serial link, synchronised into `clk`.
- Writes each instruction byte into the core's 16-entry instruction memory through a write strobe/address/data port.
- Releases the core (`core_run`) only after the whole frame has been received and its checksum verified.

## Interface

- No parameters: data width fixed at 8, address width at 4 (16 instructions).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `spi_sck` in 1: serial clock, asynchronous to `clk`; data sampled on its rising edge.
- `spi_mosi` in 1: serial data, MSB first.
- `spi_cs_n` in 1: frame select, active low, asynchronous.
- `wr_en` out 1: one-cycle instruction-memory write strobe.
- `wr_addr` out 4: write address, valid when `wr_en`=1.
- `wr_data` out 8: write data, valid when `wr_en`=1.
- `core_run` out 1: high when a verified image is loaded; core held idle while low.
- `load_err` out 1: sticky error flag for the last frame.
- `state_dbg` out 3: current FSM state encoding, for debug.

## Operation

- Input sync: `spi_sck`, `spi_mosi` and `spi_cs_n` each pass through a 2-flop synchroniser, then a 1-flop edge detector.
- Bit sampling: on each detected rising edge of synced `spi_sck` while synced `spi_cs_n`=0, shift synced `spi_mosi` into an 8-bit shift register (MSB first) and increment a 3-bit bit counter.
- A byte is complete when the bit counter wraps 7→0.
- Frame format:
  - Header byte: [7:4]=4'hA (magic), [3:0]=N-1.
  - N data bytes (1..16).
  - Checksum byte = 8-bit modular sum of the N data bytes.
- FSM states: IDLE=0, HEADER=1, DATA=2, CHECK=3, DONE=4, ERROR=5.
  - IDLE: falling edge of `spi_cs_n` → HEADER. Bit counter, address counter and sum are cleared; `load_err` is cleared; `core_run` drops to 0.
  - HEADER: on byte complete, magic = 4'hA → DATA, with the count register loaded from [3:0]. Otherwise → ERROR.
  - DATA: on byte complete:
    - Pulse `wr_en`, with `wr_addr`=address counter and `wr_data`=byte.
    - Add the byte to the sum, increment the address counter.
    - After byte N → CHECK.
  - CHECK: on byte complete, byte == sum → DONE, else → ERROR.
  - DONE: `core_run`=1.
  - ERROR: `load_err`=1, `core_run`=0.
  - DONE and ERROR: a falling edge of `spi_cs_n` restarts the load (acts as IDLE entry).
- Abort and overrun:
  - Rising edge of `spi_cs_n` in HEADER, DATA or CHECK → ERROR. This covers a partial byte or missing bytes.
  - Any completed byte in DONE before `spi_cs_n` rises → ERROR.
- Bytes already written before an error are not rolled back; `core_run` stays 0.
- Arithmetic:
  - Sum is 8-bit and wraps mod 256.
  - Address counter is 4-bit; it cannot wrap because N ≤ 16.
- The loader never writes more than N locations. Entries at addresses ≥ N keep their previous contents.

## Timing

- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `core_run`=0, `load_err`=0, `state_dbg`=0 (IDLE). Synchroniser flops reset to idle levels: sck=0, mosi=0, cs_n=1.
- `rst` asserted mid-frame → IDLE on the next edge with all outputs at reset values. The remainder of that frame is ignored until `spi_cs_n` goes high and then low again.
- Input latency: a pin change is seen by the FSM 3 `clk` cycles later (2 sync + 1 edge detect).
- Let S be the cycle in which the 8th rising sck edge of a byte is detected.
  - `wr_en` is high in cycle S+1 for exactly 1 cycle.
  - `wr_addr`/`wr_data` are registered and hold their values until the next write.
- State transitions to DONE or ERROR are registered at S+1. `core_run` and `load_err` are high from S+1.
- For a `spi_cs_n` abort, ERROR is registered one cycle after the detected cs_n rise.
- Link constraint: `spi_sck` high and low phases each ≥ 3 `clk` periods. `spi_mosi` must be stable for ≥ 3 `clk` periods around each sck rise. Faster links are unsupported.
- Simultaneous events: if a byte completes in the same cycle that the `spi_cs_n` rise is detected, the byte is processed first. That byte may complete CHECK → DONE; otherwise the cs_n rise applies.

## Test plan

- Good load: header 0xA1, data 0x81, 0x48, checksum 0xC9, then cs_n high.
  - Exactly two `wr_en` pulses: (addr 0, 0x81) and (addr 1, 0x48).
  - DONE; `core_run`=1, `load_err`=0.
- Full image: header 0xAF, 16 bytes 0x00..0x0F, checksum 0x78.
  - 16 pulses at addresses 0..15 with data equal to the address.
  - `core_run`=1.
- Bad checksum: header 0xA0, data 0xC0, checksum 0xC1.
  - One write (addr 0, 0xC0), then ERROR; `load_err`=1, `core_run`=0.
- Bad magic: header 0x51.
  - No `wr_en` pulses; ERROR after the 8th bit.
  - A following good frame clears `load_err` and sets `core_run`=1.
- Abort: cs_n rises after 4 bits of the second data byte of header 0xA3.
  - One write only, then ERROR.
  - Also: extra byte after a correct checksum → ERROR.
- Reset mid-frame: assert `rst` for 1 cycle during data byte 1.
  - All outputs return to reset values.
  - Remaining sck edges produce no `wr_en` until a new cs_n falling edge.
